// File: rtl/lsu_dcache_arb_if.sv
// Request/response bundle between the two LSU requesters, the arbiter and the DCache port.
// slave is the arbiter's view; master is the view of everything around it.
interface lsu_dcache_arb_if #(
  parameter int REQ_W  = 128,
  parameter int RESP_W = 96
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [REQ_W-1:0]  req0_data_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [REQ_W-1:0]  req1_data_i;
  logic              req1_urgent_i;
  logic              cache_valid_o;
  logic              cache_ready_i;
  logic [REQ_W-1:0]  cache_req_o;
  logic              cache_resp_valid_i;
  logic              cache_resp_ready_o;
  logic [RESP_W-1:0] cache_resp_i;
  logic              resp0_valid_o;
  logic              resp0_ready_i;
  logic [RESP_W-1:0] resp0_o;
  logic              resp1_valid_o;
  logic              resp1_ready_i;
  logic [RESP_W-1:0] resp1_o;

  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, req1_urgent_i,
           cache_ready_i, cache_resp_valid_i, cache_resp_i, resp0_ready_i, resp1_ready_i,
    output req0_ready_o, req1_ready_o, cache_valid_o, cache_req_o, cache_resp_ready_o,
           resp0_valid_o, resp0_o, resp1_valid_o, resp1_o
  );

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, req1_urgent_i,
           cache_ready_i, cache_resp_valid_i, cache_resp_i, resp0_ready_i, resp1_ready_i,
    input  req0_ready_o, req1_ready_o, cache_valid_o, cache_req_o, cache_resp_ready_o,
           resp0_valid_o, resp0_o, resp1_valid_o, resp1_o
  );
endinterface

// File: rtl/lsu_dcache_arb.sv
// Two-requester DCache port arbiter with an in-order owner/kill tag FIFO that steers
// responses back to the IQ or the store drain buffer and drops squashed IQ responses.
//
// state | meaning
// IDLE  | no pending offer; winner picked by urgency, then round-robin
// LOCK0 | IQ offer stalled by DCache; grant and payload held until handshake or flush
// LOCK1 | store-buffer offer stalled by DCache; held until handshake (flush-immune)
module lsu_dcache_arb #(
  parameter int REQ_W        = 128,
  parameter int RESP_W       = 96,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  lsu_dcache_arb_if.slave  bus,
  output logic [CNT_W-1:0] inflight_cnt_o
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} lock_e;

  lock_e                   state_q, state_d, arb_state;
  logic                    last_grant_q, last_grant_d;
  logic [MAX_INFLIGHT-1:0] owner_q, kill_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic              full, empty, req0_eff;
  logic              win, win_valid, push, pop;
  logic              head_owner, head_kill;
  logic [REQ_W-1:0]  win_data;
  logic [RESP_W-1:0] resp_data;

  assign full       = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign empty      = (cnt_q == '0);
  assign req0_eff   = bus.req0_valid_i & ~flush;
  assign head_owner = owner_q[rd_ptr_q];
  assign head_kill  = kill_q[rd_ptr_q];

  // A flush releases an IQ lock in the same cycle so the store buffer can be served at once
  assign arb_state = (state_q == LOCK0 && flush) ? IDLE : state_q;

  always_comb begin
    win       = 1'b0;
    win_valid = 1'b0;
    case (arb_state)
      LOCK0: begin
        win       = 1'b0;
        win_valid = req0_eff;
      end
      LOCK1: begin
        win       = 1'b1;
        win_valid = bus.req1_valid_i;
      end
      default: begin
        if (bus.req1_urgent_i && bus.req1_valid_i) begin
          win       = 1'b1;
          win_valid = 1'b1;
        end else if (req0_eff && bus.req1_valid_i) begin
          win       = ~last_grant_q;
          win_valid = 1'b1;
        end else if (req0_eff) begin
          win       = 1'b0;
          win_valid = 1'b1;
        end else begin
          win       = 1'b1;
          win_valid = bus.req1_valid_i;
        end
      end
    endcase
  end

  assign win_data          = win ? bus.req1_data_i : bus.req0_data_i;
  assign bus.cache_valid_o = win_valid & ~full;
  assign bus.cache_req_o   = win_data;
  assign push              = bus.cache_valid_o & bus.cache_ready_i;
  assign bus.req0_ready_o  = push & ~win;
  assign bus.req1_ready_o  = push & win;

  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    if (push) begin
      state_d      = IDLE;
      last_grant_d = win;
    end else if (bus.cache_valid_o) begin
      state_d = win ? LOCK1 : LOCK0;
    end else if (full) begin
      state_d = arb_state;
    end
  end

  always_comb begin
    bus.resp0_valid_o      = 1'b0;
    bus.resp1_valid_o      = 1'b0;
    bus.cache_resp_ready_o = 1'b0;
    if (!empty) begin
      if (head_kill) begin
        bus.cache_resp_ready_o = 1'b1;
      end else if (head_owner) begin
        bus.resp1_valid_o      = bus.cache_resp_valid_i;
        bus.cache_resp_ready_o = bus.resp1_ready_i;
      end else begin
        bus.resp0_valid_o      = bus.cache_resp_valid_i;
        bus.cache_resp_ready_o = bus.resp0_ready_i;
      end
    end
  end

  assign resp_data   = bus.cache_resp_i;
  assign bus.resp0_o = resp_data;
  assign bus.resp1_o = resp_data;
  assign pop         = bus.cache_resp_valid_i & bus.cache_resp_ready_o & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= '0;
      kill_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      // Stale slots may get kill set too; a push always rewrites kill for its slot
      if (flush) kill_q <= kill_q | ~owner_q;
      if (push) begin
        owner_q[wr_ptr_q] <= win;
        kill_q[wr_ptr_q]  <= 1'b0;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign inflight_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.cache_resp_valid_i && empty));
      assert (!(bus.resp0_valid_o && bus.resp1_valid_o));
      assert (!(bus.req0_ready_o && bus.req1_ready_o));
    end
  end

endmodule
